// File: rtl/snow64_long_div_param_radix.sv
// Unsigned WIDTH_A/WIDTH_B long divider retiring BITS_PER_ITER quotient bits per cycle.
// Optional remainder output: define SNOW64_LONG_DIV_PARAM_RADIX_REMAINDER_EN to build it (tied to 0 otherwise).
module snow64_long_div_param_radix #(
    parameter int WIDTH_A       = 16,
    parameter int WIDTH_B       = 8,
    parameter int BITS_PER_ITER = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH_A-1:0] a,
    input  logic [WIDTH_B-1:0] b,
    output logic [WIDTH_A-1:0] quotient,
    output logic [WIDTH_B-1:0] remainder,
    output logic               div_by_zero,
    output logic               valid,
    output logic               can_accept_cmd
);
    localparam int NUM_ITERS = WIDTH_A / BITS_PER_ITER;
    localparam int R         = 1 << BITS_PER_ITER;
    localparam int MW        = WIDTH_B + BITS_PER_ITER;
    localparam int CNT_W     = (NUM_ITERS > 1) ? $clog2(NUM_ITERS) : 1;

    typedef enum logic {IDLE, WORK} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH_A-1:0] quot_q, quot_d;
    logic               dbz_q, dbz_d;
    logic               valid_q, valid_d;

    logic [WIDTH_A-1:0] a_q, a_d;
    logic [MW-1:0]      cur_q, cur_d;
    logic [MW-1:0]      m_q [R];
    logic [MW-1:0]      m_d [R];

    logic [MW-1:0]            cur_sh;
    logic [MW-1:0]            m_sel;
    logic [BITS_PER_ITER-1:0] dig;
    logic [BITS_PER_ITER-1:0] cand;
    logic                     last_step;

    // The multiples table is monotonic, so the largest fitting digit is found by
    // a binary search that settles one digit bit per level, MSB first.
    always_comb begin
        cur_sh = {cur_q[WIDTH_B-1:0], a_q[WIDTH_A-1 -: BITS_PER_ITER]};
        dig    = '0;
        cand   = '0;
        for (int l = BITS_PER_ITER - 1; l >= 0; l--) begin
            cand = dig | (BITS_PER_ITER'(1) << l);
            if (m_q[cand] <= cur_sh) begin
                dig = cand;
            end
        end
        m_sel = m_q[dig];
    end

    assign last_step = (state_q == WORK) && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        dbz_d   = dbz_q;
        valid_d = valid_q;
        a_d     = a_q;
        cur_d   = cur_q;
        m_d     = m_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // A zero divisor runs a zero dividend against M[d]=d so every digit is 0.
                    a_d = (b == '0) ? '0 : a;
                    for (int d = 0; d < R; d++) begin
                        m_d[d] = (b == '0) ? MW'(d) : MW'(d) * MW'(b);
                    end
                    cnt_d   = CNT_W'(NUM_ITERS - 1);
                    cur_d   = '0;
                    dbz_d   = (b == '0);
                    valid_d = 1'b0;
                    state_d = WORK;
                end
            end
            WORK: begin
                cur_d  = cur_sh - m_sel;
                a_d    = a_q << BITS_PER_ITER;
                quot_d = (quot_q << BITS_PER_ITER) | WIDTH_A'(dig);
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quot_q  <= '0;
            dbz_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            dbz_q   <= dbz_d;
            valid_q <= valid_d;
        end
    end

    // Working datapath is always rewritten on acceptance, so it needs no reset.
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        cur_q <= cur_d;
        m_q   <= m_d;
    end

`ifdef SNOW64_LONG_DIV_PARAM_RADIX_REMAINDER_EN
    logic [WIDTH_B-1:0] rem_q, rem_d;

    // Final partial remainder is below b, so the top BITS_PER_ITER bits are zero.
    always_comb begin
        rem_d = last_step ? cur_d[WIDTH_B-1:0] : rem_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
        end else begin
            rem_q <= rem_d;
        end
    end

    assign remainder = rem_q;
`else
    assign remainder = '0;
`endif

    assign quotient       = quot_q;
    assign div_by_zero    = dbz_q;
    assign valid          = valid_q;
    assign can_accept_cmd = (state_q == IDLE);
endmodule

// File: tb/tb_snow64_long_div_param_radix.sv
// Scoreboard bench for snow64_long_div_param_radix at defaults and at 32/16/2.
module tb_snow64_long_div_param_radix;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero, valid, can_accept_cmd;

    logic        start2;
    logic [31:0] a2;
    logic [15:0] b2;
    logic [31:0] quotient2;
    logic [15:0] remainder2;
    logic        div_by_zero2, valid2, can_accept_cmd2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dbz;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    snow64_long_div_param_radix dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
        .valid(valid), .can_accept_cmd(can_accept_cmd)
    );

    snow64_long_div_param_radix #(.WIDTH_A(32), .WIDTH_B(16), .BITS_PER_ITER(2)) dut_wide (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
        .quotient(quotient2), .remainder(remainder2), .div_by_zero(div_by_zero2),
        .valid(valid2), .can_accept_cmd(can_accept_cmd2)
    );

    // Drives one accepted start and pushes the reference result.
    task automatic drive_cmd(input logic [15:0] ta, input logic [7:0] tbv);
        exp_t e;
        @(negedge clk);
        start = 1'b1; a = ta; b = tbv;
        e.dbz = (tbv == 8'd0);
        e.q   = e.dbz ? 16'd0 : ta / {8'd0, tbv};
        e.r   = e.dbz ? 8'd0 : 8'(ta % {8'd0, tbv});
`ifndef SNOW64_LONG_DIV_PARAM_RADIX_REMAINDER_EN
        e.r   = 8'd0;
`endif
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        n_checks++;
        if ({quotient, remainder, div_by_zero, valid, can_accept_cmd} !== {16'd0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: got q=%h r=%h dbz=%b v=%b rdy=%b, want 0/0/0/0/1",
                     quotient, remainder, div_by_zero, valid, can_accept_cmd);
        end
        n_checks++;
        if ({quotient2, remainder2, valid2, can_accept_cmd2} !== {32'd0, 16'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state_wide: got q=%h r=%h v=%b rdy=%b", quotient2, remainder2, valid2, can_accept_cmd2);
        end
    endtask

    task automatic test_basic;
        exp_t e;
        int   cyc;
        logic [15:0] av [3] = '{16'hFFFF, 16'd1000, 16'd5};
        logic [7:0]  bv [3] = '{8'hFF, 8'd7, 8'd9};
        for (int i = 0; i < 3; i++) begin
            drive_cmd(av[i], bv[i]);
            n_checks++;
            if ({valid, can_accept_cmd} !== 2'b00) begin
                n_fail++;
                $display("FAIL basic_busy[%0d]: got v=%b rdy=%b, want 0/0", i, valid, can_accept_cmd);
            end
            wait_valid(cyc);
            e = sb.pop_front();
            n_checks++;
            if (cyc !== 4) begin
                n_fail++;
                $display("FAIL basic_latency[%0d]: got %0d cycles, want 4", i, cyc);
            end
            n_checks++;
            if ({quotient, remainder, div_by_zero, can_accept_cmd} !== {e.q, e.r, e.dbz, 1'b1}) begin
                n_fail++;
                $display("FAIL basic_result[%0d]: got q=%0d r=%0d dbz=%b rdy=%b, want q=%0d r=%0d dbz=%b rdy=1",
                         i, quotient, remainder, div_by_zero, can_accept_cmd, e.q, e.r, e.dbz);
            end
            if (i == 1) begin
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    n_checks++;
                    if ({valid, quotient, remainder, div_by_zero} !== {1'b1, e.q, e.r, e.dbz}) begin
                        n_fail++;
                        $display("FAIL basic_hold[%0d]: got v=%b q=%0d r=%0d, want v=1 q=%0d r=%0d",
                                 k, valid, quotient, remainder, e.q, e.r);
                    end
                end
            end
        end
    endtask

    task automatic test_div_zero;
        exp_t e;
        int   cyc;
        logic [15:0] av [2] = '{16'h1234, 16'd9};
        logic [7:0]  bv [2] = '{8'd0, 8'd3};
        for (int i = 0; i < 2; i++) begin
            drive_cmd(av[i], bv[i]);
            wait_valid(cyc);
            e = sb.pop_front();
            n_checks++;
            if (cyc !== 4 || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
                n_fail++;
                $display("FAIL div_zero[%0d]: got cyc=%0d q=%0d r=%0d dbz=%b, want cyc=4 q=%0d r=%0d dbz=%b",
                         i, cyc, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
            end
        end
    endtask

    task automatic test_ignore_start;
        exp_t e;
        int   cyc;
        drive_cmd(16'd100, 8'd10);
        start = 1'b1; a = 16'd7; b = 8'd1;
        @(negedge clk);
        start = 1'b0;
        wait_valid(cyc);
        e = sb.pop_front();
        n_checks++;
        if (cyc + 1 !== 4) begin
            n_fail++;
            $display("FAIL ignore_latency: got %0d cycles, want 4", cyc + 1);
        end
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
            n_fail++;
            $display("FAIL ignore_result: got q=%0d r=%0d, want q=%0d r=%0d", quotient, remainder, e.q, e.r);
        end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        int   cyc;
        drive_cmd(16'd200, 8'd3);
        void'(sb.pop_front());
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({quotient, remainder, div_by_zero, valid, can_accept_cmd} !== {16'd0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_mid_async: got q=%h r=%h dbz=%b v=%b rdy=%b, want 0/0/0/0/1",
                     quotient, remainder, div_by_zero, valid, can_accept_cmd);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++;
            if ({valid, quotient} !== {1'b0, 16'd0}) begin
                n_fail++;
                $display("FAIL reset_mid_novalid[%0d]: got v=%b q=%h, want v=0 q=0", k, valid, quotient);
            end
        end
        drive_cmd(16'd50, 8'd5);
        wait_valid(cyc);
        e = sb.pop_front();
        n_checks++;
        if (cyc !== 4 || {quotient, remainder} !== {e.q, e.r}) begin
            n_fail++;
            $display("FAIL reset_mid_after: got cyc=%0d q=%0d r=%0d, want cyc=4 q=%0d r=%0d",
                     cyc, quotient, remainder, e.q, e.r);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   cyc;
        logic [15:0] ta;
        logic [7:0]  tbv;
        for (int i = 0; i < 16; i++) begin
            ta  = 16'($urandom);
            tbv = 8'($urandom);
            if (i == 3) tbv = 8'd1;
            if (i == 5) tbv = 8'd0;
            if (i == 7) begin ta = 16'hFFFF; tbv = 8'd1; end
            if (i == 9) begin ta = 16'd0; tbv = 8'hFF; end
            drive_cmd(ta, tbv);
            n_checks++;
            if (valid !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_valid_drop[%0d]: got v=%b, want 0", i, valid);
            end
            wait_valid(cyc);
            e = sb.pop_front();
            n_checks++;
            if (cyc !== 4 || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
                n_fail++;
                $display("FAIL b2b_result[%0d]: a=%0d b=%0d got cyc=%0d q=%0d r=%0d dbz=%b, want cyc=4 q=%0d r=%0d dbz=%b",
                         i, ta, tbv, cyc, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
            end
        end
    endtask

    task automatic test_wide;
        int          cyc;
        logic [15:0] rexp;
        rexp = 16'h076B;
`ifndef SNOW64_LONG_DIV_PARAM_RADIX_REMAINDER_EN
        rexp = 16'h0000;
`endif
        @(negedge clk);
        start2 = 1'b1; a2 = 32'hDEADBEEF; b2 = 16'h1234;
        @(negedge clk);
        start2 = 1'b0;
        cyc = 0;
        while (!valid2 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc !== 16) begin
            n_fail++;
            $display("FAIL wide_latency: got %0d cycles, want 16", cyc);
        end
        n_checks++;
        if ({quotient2, remainder2, div_by_zero2} !== {32'h000C3BA5, rexp, 1'b0}) begin
            n_fail++;
            $display("FAIL wide_result: got q=%h r=%h dbz=%b, want q=000c3ba5 r=%h dbz=0",
                     quotient2, remainder2, div_by_zero2, rexp);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        start2 = 1'b0; a2 = '0; b2 = '0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_div_zero();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
